// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer
//   Command-driven controller for a WIDTH-bit bank of JK flip-flops. It accepts one command
//   at a time over a valid/ready handshake. Each command becomes per-bit J/K drive vectors,
//   applied over one or more cycles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  command can be accepted (IDLE only)
//   cmd_op     opcode: NOP/CLEAR/SET/LOAD/TOGGLE/COUNT_UP/COUNT_DOWN/SHIFT_LEFT
//   cmd_data   load pattern / toggle mask / serial-in (bit 0)
//   cmd_count  step count for repeated ops (opcodes 1xx)
//   j_vec      J drive applied to the bank this cycle
//   k_vec      K drive applied to the bank this cycle
//   q, q_n     bank state and its complement
//   busy       high in EXEC or DONE
//   done       one-cycle completion pulse
module jk_bank_sequencer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   output logic [WIDTH-1:0] j_vec,
   output logic [WIDTH-1:0] k_vec,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   localparam logic [2:0] OpNop    = 3'b000;
   localparam logic [2:0] OpClear  = 3'b001;
   localparam logic [2:0] OpSet    = 3'b010;
   localparam logic [2:0] OpLoad   = 3'b011;
   localparam logic [2:0] OpToggle = 3'b100;
   localparam logic [2:0] OpCntUp  = 3'b101;
   localparam logic [2:0] OpCntDn  = 3'b110;
   localparam logic [2:0] OpShl    = 3'b111;

   state_e             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   bank_q;
   logic [WIDTH-1:0]   up_t, dn_t, shl;
   logic               accept;
   logic               cmd_rep;

   assign accept  = cmd_valid && (state_q == StIdle);
   // Opcodes 1xx are the repeated operations.
   assign cmd_rep = cmd_op[2];

   // Toggle-enable chains for binary up/down counting.
   always_comb begin
      up_t    = '0;
      dn_t    = '0;
      up_t[0] = 1'b1;
      dn_t[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         up_t[i] = up_t[i-1] & bank_q[i-1];
         dn_t[i] = dn_t[i-1] & ~bank_q[i-1];
      end
   end

   assign shl = {bank_q[WIDTH-2:0], data_q[0]};

   // J/K drive is only non-zero while executing, so the bank holds elsewhere.
   always_comb begin
      j_vec = '0;
      k_vec = '0;
      if (state_q == StExec) begin
         unique case (op_q)
            OpClear:  k_vec = '1;
            OpSet:    j_vec = '1;
            OpLoad:   begin j_vec = data_q; k_vec = ~data_q; end
            OpToggle: begin j_vec = data_q; k_vec = data_q;  end
            OpCntUp:  begin j_vec = up_t;   k_vec = up_t;    end
            OpCntDn:  begin j_vec = dn_t;   k_vec = dn_t;    end
            OpShl:    begin j_vec = shl;    k_vec = ~shl;    end
            default:  ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      data_d  = data_q;
      rem_d   = rem_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               op_d   = cmd_op;
               data_d = cmd_data;
               if (cmd_op == OpNop || (cmd_rep && cmd_count == '0)) begin
                  rem_d   = '0;
                  state_d = StDone;
               end else begin
                  rem_d   = cmd_rep ? cmd_count : CNT_W'(1);
                  state_d = StExec;
               end
            end
         end
         StExec: begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         op_q    <= '0;
         data_q  <= '0;
         rem_q   <= '0;
         bank_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         bank_q  <= (j_vec & ~bank_q) | (~k_vec & bank_q);
      end
   end

   assign q         = bank_q;
   assign q_n       = ~bank_q;
   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q == StExec) || (state_q == StDone);
   assign done      = (state_q == StDone);

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer
//   Directed bench for jk_bank_sequencer (WIDTH=8, CNT_W=8). Inputs change on the falling
//   edge; outputs are sampled on the falling edge, away from the active rising edge.
module tb_jk_bank_sequencer;

   localparam logic [2:0] OpNop    = 3'b000;
   localparam logic [2:0] OpLoad   = 3'b011;
   localparam logic [2:0] OpToggle = 3'b100;
   localparam logic [2:0] OpCntUp  = 3'b101;
   localparam logic [2:0] OpCntDn  = 3'b110;
   localparam logic [2:0] OpShl    = 3'b111;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_data;
   logic [7:0] cmd_count;
   logic [7:0] j_vec;
   logic [7:0] k_vec;
   logic [7:0] q;
   logic [7:0] q_n;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   jk_bank_sequencer #(
      .WIDTH(8),
      .CNT_W(8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_count (cmd_count),
      .j_vec     (j_vec),
      .k_vec     (k_vec),
      .q         (q),
      .q_n       (q_n),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the accept edge.
   task automatic send(input logic [2:0] op, input logic [7:0] data, input logic [7:0] cnt);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_count = cnt;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic expect_step(input string tag, input logic [7:0] exp_q, input logic exp_done);
      @(negedge clk);
      check({tag, ".q"}, 32'(q), 32'(exp_q));
      check({tag, ".done"}, 32'(done), 32'(exp_done));
   endtask

   task automatic load(input logic [7:0] v);
      send(OpLoad, v, 8'd0);
      expect_step("load", v, 1'b1);
      expect_step("load_idle", v, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_data  = '0;
      cmd_count = '0;

      // 1. Asynchronous reset before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      check("rst.q", 32'(q), 32'h00);
      check("rst.done", 32'(done), 32'h0);
      check("rst.ready", 32'(cmd_ready), 32'h1);
      check("rst.busy", 32'(busy), 32'h0);
      check("rst.jk", 32'({j_vec, k_vec}), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst.q", 32'(q), 32'h00);

      // 2. LOAD 0xA5.
      send(OpLoad, 8'hA5, 8'd0);
      check("ld.busy", 32'(busy), 32'h1);
      check("ld.ready", 32'(cmd_ready), 32'h0);
      check("ld.q_early", 32'(q), 32'h00);
      check("ld.j", 32'(j_vec), 32'hA5);
      check("ld.k", 32'(k_vec), 32'h5A);
      expect_step("ld.e1", 8'hA5, 1'b1);
      check("ld.q_n", 32'(q_n), 32'h5A);
      expect_step("ld.e2", 8'hA5, 1'b0);
      check("ld.ready_back", 32'(cmd_ready), 32'h1);

      // 3. COUNT_UP x3 from 0xFE, wrapping through 0.
      load(8'hFE);
      send(OpCntUp, 8'h00, 8'd3);
      expect_step("up.e1", 8'hFF, 1'b0);
      expect_step("up.e2", 8'h00, 1'b0);
      expect_step("up.e3", 8'h01, 1'b1);
      expect_step("up.e4", 8'h01, 1'b0);
      check("up.ready", 32'(cmd_ready), 32'h1);

      // 4. COUNT_DOWN x2 from 0x00, then TOGGLE 0x0F x2.
      load(8'h00);
      send(OpCntDn, 8'h00, 8'd2);
      expect_step("dn.e1", 8'hFF, 1'b0);
      expect_step("dn.e2", 8'hFE, 1'b1);
      expect_step("dn.e3", 8'hFE, 1'b0);
      send(OpToggle, 8'h0F, 8'd2);
      expect_step("tg.e1", 8'hF1, 1'b0);
      expect_step("tg.e2", 8'hFE, 1'b1);
      expect_step("tg.e3", 8'hFE, 1'b0);

      // 5. SHIFT_LEFT x3 with serial-in 1; a LOAD offered while busy is ignored.
      load(8'h00);
      send(OpShl, 8'h01, 8'd3);
      cmd_valid = 1'b1;
      cmd_op    = OpLoad;
      cmd_data  = 8'h55;
      expect_step("sh.e1", 8'h01, 1'b0);
      expect_step("sh.e2", 8'h03, 1'b0);
      expect_step("sh.e3", 8'h07, 1'b1);
      expect_step("sh.e4", 8'h07, 1'b0);
      cmd_valid = 1'b0;
      check("sh.ready", 32'(cmd_ready), 32'h1);
      expect_step("sh.ignored", 8'h07, 1'b0);
      check("sh.busy", 32'(busy), 32'h0);

      // 6. Zero-count repeat and NOP complete without touching the bank.
      send(OpCntUp, 8'h00, 8'd0);
      check("cnt0.done", 32'(done), 32'h1);
      check("cnt0.q", 32'(q), 32'h07);
      expect_step("cnt0.after", 8'h07, 1'b0);
      send(OpNop, 8'hFF, 8'd5);
      check("nop.done", 32'(done), 32'h1);
      check("nop.q", 32'(q), 32'h07);
      expect_step("nop.after", 8'h07, 1'b0);
      check("nop.ready", 32'(cmd_ready), 32'h1);

      // Reset in the middle of COUNT_UP x10.
      send(OpCntUp, 8'h00, 8'd10);
      expect_step("abort.e1", 8'h08, 1'b0);
      expect_step("abort.e2", 8'h09, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("abort.q", 32'(q), 32'h00);
      check("abort.done", 32'(done), 32'h0);
      check("abort.ready", 32'(cmd_ready), 32'h1);
      check("abort.busy", 32'(busy), 32'h0);
      for (int i = 0; i < 3; i++) begin
         expect_step("abort.hold", 8'h00, 1'b0);
      end
      rst_n = 1'b1;
      expect_step("abort.release", 8'h00, 1'b0);

      // Works normally after the abort.
      load(8'h3C);
      check("final.q_n", 32'(q_n), 32'hC3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
